// File: rtl/mem_req_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter_pkg
//   Shared definitions for the memory request arbiter: FSM state encodings,
//   grant identifiers and a helper for sizing the beat counter.
// -----------------------------------------------------------------------------
package mem_req_arbiter_pkg;

  // Burst sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  // Owner of the memory port / round-robin history.
  typedef enum logic {
    GNT_IC = 1'b0,
    GNT_DC = 1'b1
  } gnt_t;

  // Beat counter width: clog2(BURST), but never narrower than one bit so a
  // single-beat burst still has a legal counter.
  function automatic int beat_cnt_width(input int burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter_rr_arb2
//   Two-input round-robin picker. Purely combinational; the caller owns the
//   last_grant history register and updates it when a grant is taken.
// Ports
//   req_ic      in   icache request pending
//   req_dc      in   dcache request pending
//   last_grant  in   requester served most recently
//   grant_valid out  at least one request pending
//   grant       out  chosen requester (only meaningful with grant_valid)
// -----------------------------------------------------------------------------
module mem_req_arbiter_rr_arb2
  import mem_req_arbiter_pkg::*;
(
  input  logic req_ic,
  input  logic req_dc,
  input  gnt_t last_grant,
  output logic grant_valid,
  output gnt_t grant
);

  always_comb begin
    grant_valid = req_ic | req_dc;
    grant       = GNT_IC;
    if (req_ic && req_dc) begin
      // Contention: favour whoever was not served last.
      grant = (last_grant == GNT_IC) ? GNT_DC : GNT_IC;
    end else if (req_dc) begin
      grant = GNT_DC;
    end else begin
      grant = GNT_IC;
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// -----------------------------------------------------------------------------
// mem_req_arbiter
//   Shares the single external memory request port between the icache and
//   dcache miss engines. One burst at a time: icache refill, dcache refill or
//   dcache writeback. Each burst runs command -> write beats (writeback only)
//   -> read beats (refill only), and returned beats are steered to the owner.
//
// Parameters
//   ADDR_W  byte address width on both sides
//   DATA_W  width of one memory data beat
//   BURST   beats per transaction (power of 2, >= 1)
//
// Ports
//   CLK, reset                     clock, synchronous active-high reset
//   ic_req_valid/addr/ready        icache refill request handshake
//   ic_rdata_valid                 refill beat on rdata belongs to icache
//   dc_req_valid/rnw/addr/ready    dcache request handshake (rnw=0 writeback)
//   dc_wdata, dc_wdata_ready       writeback beat; dcache advances on ready
//   dc_rdata_valid                 refill beat on rdata belongs to dcache
//   rdata                          shared returned beat bus
//   mem_cmd_valid/rnw/addr/ready   command channel to memory
//   mem_wdata_valid/wdata/ready    write beat channel to memory
//   mem_rdata_valid/rdata          read beat channel from memory
// -----------------------------------------------------------------------------
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128,
  parameter int BURST  = 2
) (
  input  logic              CLK,
  input  logic              reset,

  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_rdata_valid,

  input  logic              dc_req_valid,
  input  logic              dc_req_rnw,
  input  logic [ADDR_W-1:0] dc_req_addr,
  output logic              dc_req_ready,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic              dc_wdata_ready,
  output logic              dc_rdata_valid,

  output logic [DATA_W-1:0] rdata,

  output logic              mem_cmd_valid,
  output logic              mem_cmd_rnw,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  input  logic              mem_cmd_ready,

  output logic              mem_wdata_valid,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wdata_ready,

  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BEAT_W = beat_cnt_width(BURST);
  localparam int OFF_W  = $clog2(DATA_W / 8);

  // Byte-offset bits inside one beat; these are cleared on the command address.
  localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST - 1);

  // ---------------------------------------------------------------------------
  // Registered copies of the request inputs. Arbitration looks only at these,
  // which keeps the cache-side request paths off the grant logic.
  // ---------------------------------------------------------------------------
  logic              ic_req_valid_reg;
  logic [ADDR_W-1:0] ic_req_addr_reg;
  logic              dc_req_valid_reg;
  logic              dc_req_rnw_reg;
  logic [ADDR_W-1:0] dc_req_addr_reg;

  // Sequencer state.
  state_t            state_reg;
  logic [BEAT_W-1:0] beat_cnt_reg;
  gnt_t              last_grant_reg;
  gnt_t              owner_reg;
  logic              rnw_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              ic_req_ready_reg;
  logic              dc_req_ready_reg;
  logic              mem_cmd_valid_reg;

  // Arbitration result.
  logic              grant_valid;
  gnt_t              grant;
  logic [ADDR_W-1:0] grant_addr;
  logic              grant_rnw;

  mem_req_arbiter_rr_arb2 u_rr_arb2 (
    .req_ic      (ic_req_valid_reg),
    .req_dc      (dc_req_valid_reg),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // icache only ever refills, so its grant is always a read.
  assign grant_addr = (grant == GNT_IC) ? ic_req_addr_reg : dc_req_addr_reg;
  assign grant_rnw  = (grant == GNT_IC) ? 1'b1 : dc_req_rnw_reg;

  // ---------------------------------------------------------------------------
  // Burst sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (reset) begin
      ic_req_valid_reg  <= 1'b0;
      ic_req_addr_reg   <= '0;
      dc_req_valid_reg  <= 1'b0;
      dc_req_rnw_reg    <= 1'b0;
      dc_req_addr_reg   <= '0;
      state_reg         <= ST_IDLE;
      beat_cnt_reg      <= '0;
      last_grant_reg    <= GNT_IC;
      owner_reg         <= GNT_IC;
      rnw_reg           <= 1'b0;
      addr_reg          <= '0;
      ic_req_ready_reg  <= 1'b0;
      dc_req_ready_reg  <= 1'b0;
      mem_cmd_valid_reg <= 1'b0;
    end else begin
      ic_req_valid_reg <= ic_req_valid;
      ic_req_addr_reg  <= ic_req_addr;
      dc_req_valid_reg <= dc_req_valid;
      dc_req_rnw_reg   <= dc_req_rnw;
      dc_req_addr_reg  <= dc_req_addr;

      // Request-ready is a single-cycle pulse raised only by a grant below.
      ic_req_ready_reg <= 1'b0;
      dc_req_ready_reg <= 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (grant_valid) begin
            owner_reg         <= grant;
            last_grant_reg    <= grant;
            rnw_reg           <= grant_rnw;
            addr_reg          <= grant_addr & ~OFF_MASK;
            ic_req_ready_reg  <= (grant == GNT_IC);
            dc_req_ready_reg  <= (grant == GNT_DC);
            mem_cmd_valid_reg <= 1'b1;
            state_reg         <= ST_CMD;
          end
        end

        ST_CMD: begin
          // Command fields stay frozen in addr_reg/rnw_reg until accepted.
          if (mem_cmd_ready) begin
            mem_cmd_valid_reg <= 1'b0;
            beat_cnt_reg      <= '0;
            state_reg         <= rnw_reg ? ST_RDATA : ST_WDATA;
          end
        end

        ST_WDATA: begin
          if (mem_wdata_ready) begin
            if (beat_cnt_reg == LAST_BEAT) begin
              beat_cnt_reg <= '0;
              state_reg    <= ST_IDLE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
            end
          end
        end

        ST_RDATA: begin
          if (mem_rdata_valid) begin
            if (beat_cnt_reg == LAST_BEAT) begin
              beat_cnt_reg <= '0;
              state_reg    <= ST_IDLE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  logic in_wdata;
  logic in_rdata;

  assign in_wdata = (state_reg == ST_WDATA);
  assign in_rdata = (state_reg == ST_RDATA);

  assign ic_req_ready  = ic_req_ready_reg;
  assign dc_req_ready  = dc_req_ready_reg;

  assign mem_cmd_valid = mem_cmd_valid_reg;
  assign mem_cmd_rnw   = rnw_reg;
  assign mem_cmd_addr  = addr_reg;

  // Writeback beats flow straight through; the dcache advances its beat
  // pointer in the same cycle memory takes the current one.
  assign mem_wdata_valid = in_wdata;
  assign mem_wdata       = dc_wdata;
  assign dc_wdata_ready  = in_wdata & mem_wdata_ready;

  // Read beats are forwarded unbuffered; stray beats outside a read burst
  // are dropped because in_rdata gates both qualifiers.
  assign rdata          = mem_rdata;
  assign ic_rdata_valid = in_rdata & (owner_reg == GNT_IC) & mem_rdata_valid;
  assign dc_rdata_valid = in_rdata & (owner_reg == GNT_DC) & mem_rdata_valid;

endmodule
